// File: rtl/sh_dbus_arbiter_pkg.sv
// sh_dbus_arbiter_pkg: shared bus-owner and master-bundle types for the data-bus arbiter.
package sh_dbus_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2,
    OWN_EXT  = 2'd3
  } BusOwner_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] di;
    logic [3:0]  ba;
    logic        we;
    logic        req;
    logic        lock;
  } BusMaster_t;

  localparam int FAIR_W = 4;

  function automatic BusMaster_t bus_mux(input BusOwner_t own, input BusMaster_t m0,
                                         input BusMaster_t m1);
    return own == OWN_M0 ? m0 : own == OWN_M1 ? m1 : '0;
  endfunction

endpackage

// File: rtl/sh_dbus_prio.sv
// sh_dbus_prio: combinational next-owner pick used by the arbiter while idle.
module sh_dbus_prio
  import sh_dbus_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int FAIR_MAX  = 8
) (
  input  logic              ext_req_i,
  input  logic              m0_req_i,
  input  logic              m1_req_i,
  input  logic [FAIR_W-1:0] cnt_i,
  input  logic              ptr_i,
  output BusOwner_t         pick_o
);
  localparam logic [FAIR_W-1:0] FMAX = FAIR_W'(FAIR_MAX);
  BusOwner_t fix_pick, rr_pick;
  // ptr_i = 1 means M1 has first claim on the next round-robin grant
  always_comb begin
    fix_pick = (m0_req_i && (cnt_i == FMAX || !m1_req_i)) ? OWN_M0 :
               m1_req_i ? OWN_M1 : OWN_IDLE;
    rr_pick  = ptr_i ? (m1_req_i ? OWN_M1 : m0_req_i ? OWN_M0 : OWN_IDLE) :
                       (m0_req_i ? OWN_M0 : m1_req_i ? OWN_M1 : OWN_IDLE);
    pick_o   = ext_req_i ? OWN_EXT : (PRIO_MODE != 0) ? rr_pick : fix_pick;
  end
endmodule

// File: rtl/sh_dbus_arbiter.sv
// sh_dbus_arbiter: arbitrates the internal data bus between M0, M1 and an external
// bus-release request, muxing the owner onto the BSC port.
module sh_dbus_arbiter
  import sh_dbus_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int FAIR_MAX  = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        RES_N,
  input  logic [31:0] M0_A,
  input  logic [31:0] M0_DI,
  input  logic [3:0]  M0_BA,
  input  logic        M0_WE,
  input  logic        M0_REQ,
  input  logic        M0_LOCK,
  output logic [31:0] M0_DO,
  output logic        M0_BUSY,
  input  logic [31:0] M1_A,
  input  logic [31:0] M1_DI,
  input  logic [3:0]  M1_BA,
  input  logic        M1_WE,
  input  logic        M1_REQ,
  input  logic        M1_LOCK,
  output logic [31:0] M1_DO,
  output logic        M1_BUSY,
  output logic [31:0] T_A,
  output logic [31:0] T_DO,
  output logic [3:0]  T_BA,
  output logic        T_WE,
  output logic        T_REQ,
  output logic        T_LOCK,
  input  logic [31:0] T_DI,
  input  logic        T_BUSY,
  input  logic        EXT_REQ_N,
  output logic        EXT_ACK_N,
  output logic        BUS_RLS,
  output logic [1:0]  OWNER
);
  localparam logic [FAIR_W-1:0] FMAX = FAIR_W'(FAIR_MAX);

  BusOwner_t         owner_q, owner_d, own, pick;
  BusMaster_t        m0, m1, t;
  logic [FAIR_W-1:0] cnt_q, cnt_d;
  logic              ptr_q, ptr_d;
  logic              kill;

  assign m0   = {M0_A, M0_DI, M0_BA, M0_WE, M0_REQ, M0_LOCK};
  assign m1   = {M1_A, M1_DI, M1_BA, M1_WE, M1_REQ, M1_LOCK};
  // a soft reset already blanks the bus in the cycle it is sampled
  assign kill = !RES_N && CE_R;
  assign own  = kill ? OWN_IDLE : owner_q;
  assign t    = bus_mux(own, m0, m1);

  sh_dbus_prio #(
    .PRIO_MODE(PRIO_MODE),
    .FAIR_MAX (FAIR_MAX)
  ) u_prio (
    .ext_req_i(!EXT_REQ_N),
    .m0_req_i (M0_REQ),
    .m1_req_i (M1_REQ),
    .cnt_i    (cnt_q),
    .ptr_i    (ptr_q),
    .pick_o   (pick)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      owner_q <= OWN_IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
    end else if (CE_R) begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (!RES_N) begin
      owner_d = OWN_IDLE;
      cnt_d   = '0;
      ptr_d   = 1'b0;
    end else begin
      case (owner_q)
        OWN_IDLE: begin
          owner_d = pick;
          ptr_d   = pick == OWN_M0 ? 1'b1 : pick == OWN_M1 ? 1'b0 : ptr_q;
          cnt_d   = (pick == OWN_M0 || !M0_REQ) ? '0 :
                    (pick == OWN_M1 && cnt_q != FMAX) ? cnt_q + 1'b1 : cnt_q;
        end
        OWN_EXT: owner_d = EXT_REQ_N ? OWN_IDLE : OWN_EXT;
        // a granted master keeps the bus while locked or mid-transfer
        default: owner_d = (t.lock || (t.req && T_BUSY)) ? owner_q : OWN_IDLE;
      endcase
    end
  end

  always_comb begin
    T_A       = t.a;
    T_DO      = t.di;
    T_BA      = t.ba;
    T_WE      = t.we;
    T_REQ     = t.req;
    T_LOCK    = t.lock;
    M0_DO     = own == OWN_M0 ? T_DI : '0;
    M1_DO     = own == OWN_M1 ? T_DI : '0;
    M0_BUSY   = M0_REQ && (own != OWN_M0 || T_BUSY);
    M1_BUSY   = M1_REQ && (own != OWN_M1 || T_BUSY);
    EXT_ACK_N = own != OWN_EXT;
    BUS_RLS   = own == OWN_EXT;
    OWNER     = own;
  end
endmodule

// File: tb/tb_sh_dbus_arbiter.sv
// tb_sh_dbus_arbiter: directed and random checks of fixed-priority and round-robin arbiters
// against a behavioural owner model.
module tb_sh_dbus_arbiter;
  localparam int FAIR = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1, CE_R = 1'b1, RES_N = 1'b1, EXT_REQ_N = 1'b1, T_BUSY = 1'b0;
  logic [31:0] M0_A = '0, M0_DI = '0, M1_A = '0, M1_DI = '0, T_DI = '0;
  logic [3:0]  M0_BA = '0, M1_BA = '0;
  logic        M0_WE = 1'b0, M0_REQ = 1'b0, M0_LOCK = 1'b0;
  logic        M1_WE = 1'b0, M1_REQ = 1'b0, M1_LOCK = 1'b0;

  logic [31:0] f_M0_DO, f_M1_DO, f_T_A, f_T_DO, r_M0_DO, r_M1_DO, r_T_A, r_T_DO;
  logic [3:0]  f_T_BA, r_T_BA;
  logic        f_M0_BUSY, f_M1_BUSY, f_T_WE, f_T_REQ, f_T_LOCK, f_EXT_ACK_N, f_BUS_RLS;
  logic        r_M0_BUSY, r_M1_BUSY, r_T_WE, r_T_REQ, r_T_LOCK, r_EXT_ACK_N, r_BUS_RLS;
  logic [1:0]  f_OWNER, r_OWNER;
  logic [140:0] f_obs, r_obs;

  int compared = 0, mism = 0;
  int of = 0, cf = 0, pf = 0, orr = 0, cr = 0, pr = 0;

  always #5 CLK = ~CLK;

  sh_dbus_arbiter #(.PRIO_MODE(0), .FAIR_MAX(FAIR)) u_fix (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .RES_N(RES_N),
    .M0_A(M0_A), .M0_DI(M0_DI), .M0_BA(M0_BA), .M0_WE(M0_WE), .M0_REQ(M0_REQ),
    .M0_LOCK(M0_LOCK), .M0_DO(f_M0_DO), .M0_BUSY(f_M0_BUSY),
    .M1_A(M1_A), .M1_DI(M1_DI), .M1_BA(M1_BA), .M1_WE(M1_WE), .M1_REQ(M1_REQ),
    .M1_LOCK(M1_LOCK), .M1_DO(f_M1_DO), .M1_BUSY(f_M1_BUSY),
    .T_A(f_T_A), .T_DO(f_T_DO), .T_BA(f_T_BA), .T_WE(f_T_WE), .T_REQ(f_T_REQ),
    .T_LOCK(f_T_LOCK), .T_DI(T_DI), .T_BUSY(T_BUSY), .EXT_REQ_N(EXT_REQ_N),
    .EXT_ACK_N(f_EXT_ACK_N), .BUS_RLS(f_BUS_RLS), .OWNER(f_OWNER)
  );

  sh_dbus_arbiter #(.PRIO_MODE(1), .FAIR_MAX(FAIR)) u_rr (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .RES_N(RES_N),
    .M0_A(M0_A), .M0_DI(M0_DI), .M0_BA(M0_BA), .M0_WE(M0_WE), .M0_REQ(M0_REQ),
    .M0_LOCK(M0_LOCK), .M0_DO(r_M0_DO), .M0_BUSY(r_M0_BUSY),
    .M1_A(M1_A), .M1_DI(M1_DI), .M1_BA(M1_BA), .M1_WE(M1_WE), .M1_REQ(M1_REQ),
    .M1_LOCK(M1_LOCK), .M1_DO(r_M1_DO), .M1_BUSY(r_M1_BUSY),
    .T_A(r_T_A), .T_DO(r_T_DO), .T_BA(r_T_BA), .T_WE(r_T_WE), .T_REQ(r_T_REQ),
    .T_LOCK(r_T_LOCK), .T_DI(T_DI), .T_BUSY(T_BUSY), .EXT_REQ_N(EXT_REQ_N),
    .EXT_ACK_N(r_EXT_ACK_N), .BUS_RLS(r_BUS_RLS), .OWNER(r_OWNER)
  );

  assign f_obs = {f_OWNER, f_T_A, f_T_DO, f_T_BA, f_T_WE, f_T_REQ, f_T_LOCK,
                  f_M0_DO, f_M0_BUSY, f_M1_DO, f_M1_BUSY, f_EXT_ACK_N, f_BUS_RLS};
  assign r_obs = {r_OWNER, r_T_A, r_T_DO, r_T_BA, r_T_WE, r_T_REQ, r_T_LOCK,
                  r_M0_DO, r_M0_BUSY, r_M1_DO, r_M1_BUSY, r_EXT_ACK_N, r_BUS_RLS};

  // Expected outputs for an owner (0 idle, 1 M0, 2 M1, 3 ext) and the present inputs
  function automatic logic [140:0] exp_outs(input int own_q);
    int o;
    logic [70:0] bus;
    o = (!RES_N && CE_R) ? 0 : own_q;
    bus = o == 1 ? {M0_A, M0_DI, M0_BA, M0_WE, M0_REQ, M0_LOCK} :
          o == 2 ? {M1_A, M1_DI, M1_BA, M1_WE, M1_REQ, M1_LOCK} : 71'd0;
    return {2'(o), bus, (o == 1 ? T_DI : 32'h0), M0_REQ && (o != 1 || T_BUSY),
            (o == 2 ? T_DI : 32'h0), M1_REQ && (o != 2 || T_BUSY), o != 3, o == 3};
  endfunction

  // Owner model: grants only from idle; a master keeps the bus while locked or waiting
  task automatic step(input bit rr, inout int own, inout int cnt, inout int ptr);
    int g;
    if (!CE_R) return;
    if (!RES_N) begin
      own = 0; cnt = 0; ptr = 0;
      return;
    end
    case (own)
      0: begin
        if (!EXT_REQ_N) g = 3;
        else if (rr) g = (ptr == 0) ? (M0_REQ ? 1 : M1_REQ ? 2 : 0) : (M1_REQ ? 2 : M0_REQ ? 1 : 0);
        else g = (M0_REQ && (cnt == FAIR || !M1_REQ)) ? 1 : M1_REQ ? 2 : 0;
        if (g == 1 || !M0_REQ) cnt = 0;
        else if (g == 2 && cnt < FAIR) cnt++;
        if (g == 1) ptr = 1;
        else if (g == 2) ptr = 0;
        own = g;
      end
      3: own = EXT_REQ_N ? 0 : 3;
      default: begin
        if (!((own == 1 ? M0_LOCK : M1_LOCK) || ((own == 1 ? M0_REQ : M1_REQ) && T_BUSY))) own = 0;
      end
    endcase
  endtask

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    compared += 2;
    assert (f_obs === exp_outs(of)) else begin
      mism++;
      $error("FAIL fixed_outs observed=%h expected=%h", f_obs, exp_outs(of));
    end
    assert (r_obs === exp_outs(orr)) else begin
      mism++;
      $error("FAIL rr_outs observed=%h expected=%h", r_obs, exp_outs(orr));
    end
    @(posedge CLK);
    step(1'b0, of, cf, pf);
    step(1'b1, orr, cr, pr);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    of = 0; cf = 0; pf = 0; orr = 0; cr = 0; pr = 0;
    @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  int rr_exp[12]  = '{1, 0, 2, 0, 1, 0, 2, 0, 1, 0, 2, 0};
  int fix_exp[12] = '{2, 0, 2, 0, 2, 0, 2, 0, 1, 0, 2, 0};

  initial begin
    #2 RST_N = 1'b0;
    #1;
    ck("rst_owner", 32'(f_OWNER), 0);
    ck("rst_ack_n", 32'(f_EXT_ACK_N), 1);
    ck("rst_rls", 32'(f_BUS_RLS), 0);
    ck("rst_treq", 32'(f_T_REQ), 0);
    ck("rst_rr_owner", 32'(r_OWNER), 0);
    @(posedge CLK);
    #1 RST_N = 1'b1;

    // single CPU read with two wait cycles
    M0_REQ = 1'b1; M0_A = 32'h2000_0004; T_BUSY = 1'b1; T_DI = 32'hDEAD_BEEF;
    cyc();
    #1 ck("rd_treq", 32'(f_T_REQ), 1);
    ck("rd_ta", f_T_A, 32'h2000_0004);
    cyc(); cyc();
    T_BUSY = 1'b0;
    #1 ck("rd_busy", 32'(f_M0_BUSY), 0);
    ck("rd_do", f_M0_DO, 32'hDEAD_BEEF);
    cyc();
    M0_REQ = 1'b0;
    #1 ck("rd_owner_idle", 32'(f_OWNER), 0);
    cyc();

    // fixed priority with simultaneous requests
    M0_REQ = 1'b1; M1_REQ = 1'b1; M1_A = 32'h3000_0010;
    cyc();
    #1 ck("fix_first_m1", 32'(f_OWNER), 2);
    cyc();
    M1_REQ = 1'b0;
    #1 ck("fix_bubble", 32'(f_OWNER), 0);
    cyc();
    #1 ck("fix_then_m0", 32'(f_OWNER), 1);
    cyc();
    M0_REQ = 1'b0;
    cyc();

    // continuous requests: round-robin alternation and fixed-mode fairness
    do_reset();
    M0_REQ = 1'b1; M1_REQ = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      ck("rr_seq", 32'(r_OWNER), 32'(rr_exp[i]));
      ck("fair_seq", 32'(f_OWNER), 32'(fix_exp[i]));
    end
    M0_REQ = 1'b0; M1_REQ = 1'b0;
    cyc(); cyc();

    // locked M1 sequence holds off both EXT and M0
    do_reset();
    M1_REQ = 1'b1; M1_LOCK = 1'b1;
    cyc();
    M0_REQ = 1'b1; EXT_REQ_N = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) M1_LOCK = 1'b0;
      #1 ck("lock_hold", 32'(f_OWNER), 2);
      ck("lock_hold_rr", 32'(r_OWNER), 2);
      cyc();
    end
    M1_REQ = 1'b0;
    #1 ck("lock_release", 32'(f_OWNER), 0);
    cyc();
    #1 ck("ext_owner", 32'(f_OWNER), 3);
    ck("ext_ack_n", 32'(f_EXT_ACK_N), 0);
    ck("ext_rls", 32'(f_BUS_RLS), 1);
    cyc();
    #1 ck("ext_stay", 32'(f_OWNER), 3);
    EXT_REQ_N = 1'b1;
    cyc();
    #1 ck("ext_leave", 32'(f_OWNER), 0);
    ck("ext_leave_ack", 32'(f_EXT_ACK_N), 1);
    cyc();
    #1 ck("ext_then_m0", 32'(f_OWNER), 1);
    M0_REQ = 1'b0;
    cyc();

    // asynchronous reset in the middle of a waited M0 transfer
    M0_REQ = 1'b1; T_BUSY = 1'b1;
    cyc();
    #1 ck("arst_pre_treq", 32'(f_T_REQ), 1);
    #2 RST_N = 1'b0;
    of = 0; cf = 0; pf = 0; orr = 0; cr = 0; pr = 0;
    #1 ck("arst_treq", 32'(f_T_REQ), 0);
    ck("arst_owner", 32'(f_OWNER), 0);
    ck("arst_ack_n", 32'(f_EXT_ACK_N), 1);
    ck("arst_busy", 32'(f_M0_BUSY), 1);
    ck("arst_do", f_M0_DO, 0);
    @(posedge CLK);
    #1 RST_N = 1'b1;

    // soft reset blanks the bus in the same cycle
    cyc();
    #1 ck("sres_pre_owner", 32'(f_OWNER), 1);
    RES_N = 1'b0;
    #1 ck("sres_treq", 32'(f_T_REQ), 0);
    ck("sres_owner", 32'(f_OWNER), 0);
    cyc();
    RES_N = 1'b1; M0_REQ = 1'b0; T_BUSY = 1'b0;
    #1 ck("sres_after", 32'(f_OWNER), 0);
    cyc();

    // random traffic checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      CE_R      = $urandom_range(0, 99) < 85;
      RES_N     = $urandom_range(0, 99) >= 3;
      EXT_REQ_N = $urandom_range(0, 99) >= 15;
      M0_REQ    = $urandom_range(0, 99) < 60;
      M1_REQ    = $urandom_range(0, 99) < 60;
      M0_LOCK   = $urandom_range(0, 99) < 15;
      M1_LOCK   = $urandom_range(0, 99) < 15;
      T_BUSY    = $urandom_range(0, 99) < 40;
      M0_A = $urandom(); M0_DI = $urandom(); M1_A = $urandom(); M1_DI = $urandom();
      T_DI = $urandom();
      M0_BA = 4'($urandom()); M1_BA = 4'($urandom());
      M0_WE = 1'($urandom()); M1_WE = 1'($urandom());
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
